// File: rtl/dmi_arbiter_pkg.sv
// ============================================================================
// Module   : dmi_arbiter_pkg
// Purpose  : Shared debug definitions for the DMI arbiter: default widths,
//            DMI request/response op codes and the arbiter FSM state enum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmi_arbiter_pkg;

   // Default DMI field widths and response timeout
   localparam int DMI_ADDR_BITS_DEF  = 6;
   localparam int DMI_DATA_BITS_DEF  = 32;
   localparam int DMI_OP_BITS_DEF    = 2;
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // Request op codes
   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   // Response op codes
   localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
   localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
   localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dmi_arb_state_e;

   // One-hot select for a two-requester index
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmi_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant selection. A lone requester always
//            wins; on contention the requester named by the pointer wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
   import dmi_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_rr,
   output logic       o_any,
   output logic       o_gnt
);

   // Pick the winning requester index from the request vector and pointer
   always_comb begin
      o_any = |i_req;
      case (i_req)
         2'b10:   o_gnt = 1'b1;
         2'b11:   o_gnt = i_rr;
         default: o_gnt = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmi_arbiter.sv
// ============================================================================
// Module   : dmi_arbiter
// Purpose  : Arbitrates two DMI requesters (JTAG DTM and a secondary debug
//            bridge) onto one debug module port, one transaction in flight.
//            FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Config   : DMI_ARB_TIMEOUT_EN - when defined, WAIT gives up after
//            TIMEOUT_CYCLES cycles and returns a FAILED response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_arbiter
   import dmi_arbiter_pkg::*;
#(
   parameter int DMI_ADDR_BITS  = DMI_ADDR_BITS_DEF,
   parameter int DMI_DATA_BITS  = DMI_DATA_BITS_DEF,
   parameter int DMI_OP_BITS    = DMI_OP_BITS_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic                                                  clk_i,
   input  logic                                                  rst_n,
   input  logic [1:0]                                            req_valid_i,
   input  logic [1:0][DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] req_data_i,
   output logic [1:0]                                            req_ready_o,
   output logic [1:0]                                            resp_valid_o,
   output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0]    resp_data_o,
   input  logic [1:0]                                            resp_ready_i,
   output logic                                                  dmi_req_valid_o,
   output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0]    dmi_req_data_o,
   input  logic                                                  dmi_req_ready_i,
   input  logic                                                  dmi_resp_valid_i,
   input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0]    dmi_resp_data_i
);

   localparam int W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;
   localparam logic [1:0] S_RESP  = ST_RESP;

   // A zero-cycle timeout would make WAIT meaningless
   if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_check
      $error("dmi_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]   r_state;
   logic         r_rr;
   logic         r_gnt;
   logic [1:0]   r_req_ready;
   logic         r_dmi_vld;
   logic [1:0]   r_resp_valid;
   logic [W-1:0] r_req_data;
   logic [W-1:0] r_resp_data;

   logic         w_any;
   logic         w_gnt;
   logic         w_timeout;
   logic         w_wait_done;

   rr_arb2 u_rr_arb2 (
      .i_req (req_valid_i),
      .i_rr  (r_rr),
      .o_any (w_any),
      .o_gnt (w_gnt)
   );

`ifdef DMI_ARB_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   // Count WAIT cycles without a response; cleared while the request is issued
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT) && !dmi_resp_valid_i && (r_tmo_cnt != TMO_LAST)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // The last permitted WAIT cycle passed without a response
   assign w_timeout = (r_state == S_WAIT) && !dmi_resp_valid_i && (r_tmo_cnt == TMO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // Responses only count while waiting; pulses in other states are dropped
   assign w_wait_done = (r_state == S_WAIT) && (dmi_resp_valid_i || w_timeout);

   // Transaction FSM with grant pulse, DMI request valid and response valid
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rr         <= 1'b0;
         r_gnt        <= 1'b0;
         r_req_ready  <= 2'b00;
         r_dmi_vld    <= 1'b0;
         r_resp_valid <= 2'b00;
      end else begin
         r_req_ready <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_gnt;
                  r_req_ready <= onehot2(w_gnt);
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // First ISSUE cycle raises valid; it then holds until accepted
               if (!r_dmi_vld) begin
                  r_dmi_vld <= 1'b1;
               end else if (dmi_req_ready_i) begin
                  r_dmi_vld <= 1'b0;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_wait_done) begin
                  r_resp_valid <= onehot2(r_gnt);
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready_i[r_gnt]) begin
                  r_resp_valid <= 2'b00;
                  r_rr         <= ~r_gnt;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Latch the granted payload and the debug module (or timeout) response
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_req_data  <= '0;
         r_resp_data <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_any) begin
            r_req_data <= req_data_i[w_gnt];
         end
         if (r_state == S_WAIT) begin
            if (dmi_resp_valid_i) begin
               r_resp_data <= dmi_resp_data_i;
            end else if (w_timeout) begin
               r_resp_data <= {r_req_data[W-1 -: DMI_ADDR_BITS],
                               {DMI_DATA_BITS{1'b0}},
                               DMI_OP_BITS'(DMI_RESP_FAILED)};
            end
         end
      end
   end

   assign req_ready_o     = r_req_ready;
   assign resp_valid_o    = r_resp_valid;
   assign resp_data_o     = r_resp_data;
   assign dmi_req_valid_o = r_dmi_vld;
   assign dmi_req_data_o  = r_req_data;

endmodule

`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
// ============================================================================
// Module   : tb_dmi_arbiter
// Purpose  : Self-checking bench for dmi_arbiter. Directed scenarios plus a
//            randomized run, compared against a transaction-level model of
//            the grant rule, handshake timing and response routing.
// Config   : honours DMI_ARB_TIMEOUT_EN for the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmi_arbiter;

   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int OW  = 2;
   localparam int W   = AW + DW + OW;
   localparam int TMO = 8;

   logic                clk_i = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          req_valid_i = '0;
   logic [1:0][W-1:0]   req_data_i = '0;
   logic [1:0]          req_ready_o;
   logic [1:0]          resp_valid_o;
   logic [W-1:0]        resp_data_o;
   logic [1:0]          resp_ready_i = '0;
   logic                dmi_req_valid_o;
   logic [W-1:0]        dmi_req_data_o;
   logic                dmi_req_ready_i = 1'b0;
   logic                dmi_resp_valid_i = 1'b0;
   logic [W-1:0]        dmi_resp_data_i = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int m_rr    = 0;

   always #5 clk_i = ~clk_i;

   dmi_arbiter #(
      .DMI_ADDR_BITS  (AW),
      .DMI_DATA_BITS  (DW),
      .DMI_OP_BITS    (OW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i            (clk_i),
      .rst_n            (rst_n),
      .req_valid_i      (req_valid_i),
      .req_data_i       (req_data_i),
      .req_ready_o      (req_ready_o),
      .resp_valid_o     (resp_valid_o),
      .resp_data_o      (resp_data_o),
      .resp_ready_i     (resp_ready_i),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_data_o   (dmi_req_data_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_data_i  (dmi_resp_data_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Grant rule: a lone requester wins, otherwise the pointer decides
   function automatic logic exp_grant(input logic [1:0] v, input int rr);
      if (v == 2'b01) return 1'b0;
      if (v == 2'b10) return 1'b1;
      return (rr != 0);
   endfunction

   function automatic logic [1:0] oh(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [W-1:0] rand_pl();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[W-1:0];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  64'(req_ready_o), 64'd0);
      check({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
      check({tag, "_dmi_valid"},  64'(dmi_req_valid_o), 64'd0);
      check({tag, "_dmi_data"},   64'(dmi_req_data_o), 64'd0);
      check({tag, "_resp_data"},  64'(resp_data_o), 64'd0);
   endtask

   // One complete transaction. rsp_dly < 0 means no response (timeout path).
   task automatic do_txn(input logic [1:0] valid, input logic [1:0][W-1:0] pl,
                         input logic [W-1:0] rsp, input int rdy_dly, input int rsp_dly,
                         input int hold, input bit keep_valid, input bit rst_in_wait);
      logic         g;
      logic [W-1:0] exp_req;
      logic [W-1:0] exp_rsp;
      g       = exp_grant(valid, m_rr);
      exp_req = pl[g];
      req_valid_i = valid;
      req_data_i  = pl;
      tick();
      check("grant_ready", 64'(req_ready_o), 64'(oh(g)));
      check("issue_not_yet", 64'(dmi_req_valid_o), 64'd0);
      if (!keep_valid) req_valid_i = 2'b00;
      req_data_i = {rand_pl(), rand_pl()};
      tick();
      check("ready_pulse_end", 64'(req_ready_o), 64'd0);
      check("dmi_req_valid", 64'(dmi_req_valid_o), 64'd1);
      check("dmi_req_data", 64'(dmi_req_data_o), 64'(exp_req));
      for (int i = 0; i < rdy_dly; i++) begin
         dmi_req_ready_i  = 1'b0;
         dmi_resp_valid_i = 1'($urandom_range(0, 1));
         dmi_resp_data_i  = rand_pl();
         tick();
         dmi_resp_valid_i = 1'b0;
         check("issue_hold_valid", 64'(dmi_req_valid_o), 64'd1);
         check("issue_hold_data", 64'(dmi_req_data_o), 64'(exp_req));
         check("issue_no_resp", 64'(resp_valid_o), 64'd0);
      end
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      check("wait_dmi_idle", 64'(dmi_req_valid_o), 64'd0);
      check("wait_no_resp", 64'(resp_valid_o), 64'd0);
      if (rst_in_wait) begin
         tick();
         rst_n = 1'b0;
         #1;
         check_all_zero("async_rst");
         tick();
         rst_n       = 1'b1;
         req_valid_i = 2'b00;
         m_rr        = 0;
         return;
      end
      if (rsp_dly >= 0) begin
         for (int i = 0; i < rsp_dly; i++) begin
            tick();
            check("wait_quiet", 64'(resp_valid_o), 64'd0);
         end
         dmi_resp_valid_i = 1'b1;
         dmi_resp_data_i  = rsp;
         tick();
         dmi_resp_valid_i = 1'b0;
         exp_rsp = rsp;
      end else begin
         for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("tmo_quiet", 64'(resp_valid_o), 64'd0);
         end
         tick();
         exp_rsp = {exp_req[W-1 -: AW], {DW{1'b0}}, 2'b10};
         dmi_resp_valid_i = 1'b1;
         dmi_resp_data_i  = rand_pl();
      end
      check("resp_valid", 64'(resp_valid_o), 64'(oh(g)));
      check("resp_data", 64'(resp_data_o), 64'(exp_rsp));
      for (int i = 0; i < hold; i++) begin
         tick();
         dmi_resp_valid_i = 1'b0;
         check("resp_hold_valid", 64'(resp_valid_o), 64'(oh(g)));
         check("resp_hold_data", 64'(resp_data_o), 64'(exp_rsp));
         check("resp_no_grant", 64'(req_ready_o), 64'd0);
         check("resp_no_dmi", 64'(dmi_req_valid_o), 64'd0);
      end
      resp_ready_i = oh(g);
      tick();
      resp_ready_i     = 2'b00;
      dmi_resp_valid_i = 1'b0;
      check("resp_done", 64'(resp_valid_o), 64'd0);
      m_rr = g ? 0 : 1;
      if (rsp_dly < 0) begin
         for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second_resp", 64'(resp_valid_o), 64'd0);
         end
      end
   endtask

   initial begin
      logic [1:0][W-1:0] pl;
      logic [1:0]        v;
      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single requester 0: addr 0x10, data 0x1, op WRITE; DM answers with op SUCCESS
      pl[0] = {6'h10, 32'h1, 2'd2};
      pl[1] = rand_pl();
      do_txn(2'b01, pl, {6'h10, 32'hCAFE_0001, 2'd0}, 0, 2, 0, 1'b0, 1'b0);
      // Pointer is now 1: contention goes to requester 1
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b11, pl, rand_pl(), 0, 0, 0, 1'b0, 1'b0);

      // DM stalls the request for 5 cycles
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b10, pl, rand_pl(), 5, 1, 0, 1'b0, 1'b0);

      // Requester holds off the response for 10 cycles
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b01, pl, rand_pl(), 1, 0, 10, 1'b0, 1'b0);

      // Reset while waiting for the debug module
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b10, pl, rand_pl(), 0, 0, 0, 1'b0, 1'b1);

      // Both requesting continuously: grants alternate starting from 0
      for (int t = 0; t < 4; t++) begin
         pl = {rand_pl(), rand_pl()};
         do_txn(2'b11, pl, rand_pl(), t % 2, t, 1, 1'b1, 1'b0);
      end
      req_valid_i = 2'b00;

`ifdef DMI_ARB_TIMEOUT_EN
      // No response: timeout returns FAILED, a late pulse is ignored
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b01, pl, rand_pl(), 0, -1, 2, 1'b0, 1'b0);
`else
      // Slow response well beyond any timeout still completes normally
      pl = {rand_pl(), rand_pl()};
      do_txn(2'b01, pl, rand_pl(), 0, 3 * TMO, 0, 1'b0, 1'b0);
`endif

      // Randomized traffic
      for (int t = 0; t < 24; t++) begin
         v  = 2'($urandom_range(1, 3));
         pl = {rand_pl(), rand_pl()};
         do_txn(v, pl, rand_pl(), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
